// File: rtl/lzc_norm_pipe.sv
// Two-stage leading-zero / leading-sign counter with normalising left shift.
// S1 captures operand, tag, count and zero flag; S2 holds the shifted result.
module lzc_norm_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 8,
  localparam int unsigned NUM_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             I_Valid,
  output logic             O_Rdy,
  input  logic [WIDTH-1:0] I_Data,
  input  logic             I_Mode,
  input  logic [TAG_W-1:0] I_Tag,
  output logic             O_Valid,
  input  logic             I_Rdy,
  output logic [NUM_W-1:0] O_Num,
  output logic [WIDTH-1:0] O_Data,
  output logic             O_Zero,
  output logic [TAG_W-1:0] O_Tag
);

  localparam int unsigned CW     = NUM_W - 1;
  localparam int unsigned LEAVES = WIDTH / 8;

  // 8-bit priority encoder: leading-zero count of a byte (0 when the byte is empty)
  function automatic logic [2:0] pe8(input logic [7:0] b);
    logic [2:0] c;
    c = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) c = 3'(7 - k);
    end
    return c;
  endfunction

  // Merge byte encoders pairwise up the tree; an all-zero vector reports WIDTH
  function automatic logic [NUM_W-1:0] lzc_tree(input logic [WIDTH-1:0] v);
    logic [CW-1:0] cnt [LEAVES];
    logic          zf  [LEAVES];
    int unsigned   span;
    for (int i = 0; i < int'(LEAVES); i++) begin
      cnt[i] = CW'(pe8(v[i*8 +: 8]));
      zf[i]  = (v[i*8 +: 8] == 8'd0);
    end
    span = 8;
    for (int n = int'(LEAVES / 2); n >= 1; n = n / 2) begin
      for (int j = 0; j < n; j++) begin
        cnt[j] = zf[2*j+1] ? CW'(span) + cnt[2*j] : cnt[2*j+1];
        zf[j]  = zf[2*j+1] & zf[2*j];
      end
      span = span * 2;
    end
    return zf[0] ? NUM_W'(WIDTH) : {1'b0, cnt[0]};
  endfunction

  // Log2(WIDTH)-stage barrel shifter; the top amount bit alone means "shift out everything"
  function automatic logic [WIDTH-1:0] norm_shift(input logic [WIDTH-1:0] d,
                                                  input logic [NUM_W-1:0] amt);
    logic [WIDTH-1:0] s;
    s = d;
    for (int k = 0; k < int'(CW); k++) begin
      if (amt[k]) s = s << (1 << k);
    end
    if (amt[CW]) s = '0;
    return s;
  endfunction

  logic             v1_q, v1_d;
  logic [WIDTH-1:0] data1_q, data1_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;
  logic [NUM_W-1:0] num1_q, num1_d;
  logic             zero1_q, zero1_d;

  logic             v2_q, v2_d;
  logic [WIDTH-1:0] data2_q, data2_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;
  logic [NUM_W-1:0] num2_q, num2_d;
  logic             zero2_q, zero2_d;

  logic             in_acc;
  logic             s1_to_s2;
  logic [WIDTH-1:0] lzc_vec;

  // Handshake, counting in front of S1, shifting in front of S2
  always_comb begin
    O_Rdy    = !v1_q || !v2_q || I_Rdy;
    in_acc   = I_Valid && O_Rdy;
    s1_to_s2 = v1_q && (!v2_q || I_Rdy);

    // Sign mode counts sign-equal bits below the MSB; the forced 1 caps the count at WIDTH-1
    lzc_vec = I_Mode ? {I_Data[WIDTH-2:0] ^ {(WIDTH-1){I_Data[WIDTH-1]}}, 1'b1} : I_Data;

    v1_d    = v1_q;
    data1_d = data1_q;
    tag1_d  = tag1_q;
    num1_d  = num1_q;
    zero1_d = zero1_q;
    v2_d    = v2_q;
    data2_d = data2_q;
    tag2_d  = tag2_q;
    num2_d  = num2_q;
    zero2_d = zero2_q;

    if (in_acc) begin
      v1_d    = 1'b1;
      data1_d = I_Data;
      tag1_d  = I_Tag;
      num1_d  = lzc_tree(lzc_vec);
      zero1_d = (I_Data == '0);
    end else if (s1_to_s2) begin
      v1_d = 1'b0;
    end

    if (s1_to_s2) begin
      v2_d    = 1'b1;
      data2_d = norm_shift(data1_q, num1_q);
      tag2_d  = tag1_q;
      num2_d  = num1_q;
      zero2_d = zero1_q;
    end else if (v2_q && I_Rdy) begin
      v2_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v1_q    <= 1'b0;
      data1_q <= '0;
      tag1_q  <= '0;
      num1_q  <= '0;
      zero1_q <= 1'b0;
      v2_q    <= 1'b0;
      data2_q <= '0;
      tag2_q  <= '0;
      num2_q  <= '0;
      zero2_q <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      data1_q <= data1_d;
      tag1_q  <= tag1_d;
      num1_q  <= num1_d;
      zero1_q <= zero1_d;
      v2_q    <= v2_d;
      data2_q <= data2_d;
      tag2_q  <= tag2_d;
      num2_q  <= num2_d;
      zero2_q <= zero2_d;
    end
  end

  assign O_Valid = v2_q;
  assign O_Num   = num2_q;
  assign O_Data  = data2_q;
  assign O_Zero  = zero2_q;
  assign O_Tag   = tag2_q;

endmodule
